// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A/B operands and skews them onto the edges of an N x N systolic array
module systolic_feeder #(
   parameter int DATA_W = 8,
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_compute,
   input  logic                load_en,
   input  logic                load_sel,
   input  logic [1:0]          load_row,
   input  logic [N*DATA_W-1:0] load_data,
   output logic [N*DATA_W-1:0] a_out,
   output logic [N*DATA_W-1:0] b_out,
   output logic [N-1:0]        a_vld,
   output logic [N-1:0]        b_vld,
   output logic                acc_clr,
   output logic                systolic_array_done,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
   state_t state;
   logic [2:0] step;
   logic [2:0] dcnt;
   logic [3:0] d;
   logic [N*DATA_W-1:0] a_mem [N];
   logic [N*DATA_W-1:0] b_mem [N];
   logic [N*DATA_W-1:0] a_nxt;
   logic [N*DATA_W-1:0] b_nxt;
   logic [N-1:0] av_nxt;
   logic [N-1:0] bv_nxt;
   // skew: lane i at step c carries element c-i of its row/column when that offset is in range
   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      av_nxt = '0;
      bv_nxt = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
         d = {1'b0, step} - 4'(i);
         if (d <= 4'd3) begin
            a_nxt[i*DATA_W +: DATA_W] = a_mem[i][d[1:0]*DATA_W +: DATA_W];
            b_nxt[i*DATA_W +: DATA_W] = b_mem[d[1:0]][i*DATA_W +: DATA_W];
            av_nxt[i] = 1'b1;
            bv_nxt[i] = 1'b1;
         end
      end
   end
   // control FSM with registered outputs; operand buffers are writable only while idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         step <= '0;
         dcnt <= '0;
         a_out <= '0;
         b_out <= '0;
         a_vld <= '0;
         b_vld <= '0;
         acc_clr <= 1'b0;
         systolic_array_done <= 1'b0;
         busy <= 1'b0;
         a_mem <= '{default: '0};
         b_mem <= '{default: '0};
      end else begin
         case (state)
            IDLE: begin
               if (load_en && !load_sel) a_mem[load_row] <= load_data;
               if (load_en && load_sel) b_mem[load_row] <= load_data;
               if (start_compute) begin
                  state <= FEED;
                  acc_clr <= 1'b1;
                  step <= '0;
                  busy <= 1'b1;
               end
            end
            FEED, DRAIN: begin
               acc_clr <= 1'b0;
               if (!start_compute) begin
                  state <= IDLE;
                  busy <= 1'b0;
                  a_out <= '0;
                  b_out <= '0;
                  a_vld <= '0;
                  b_vld <= '0;
               end else if (state == FEED && step == 3'd7) begin
                  state <= DRAIN;
                  dcnt <= '0;
                  a_out <= '0;
                  b_out <= '0;
                  a_vld <= '0;
                  b_vld <= '0;
               end else if (state == FEED) begin
                  a_out <= a_nxt;
                  b_out <= b_nxt;
                  a_vld <= av_nxt;
                  b_vld <= bv_nxt;
                  step <= step + 3'd1;
               end else if (dcnt == 3'd6) begin
                  state <= DONE;
                  systolic_array_done <= 1'b1;
               end else begin
                  dcnt <= dcnt + 3'd1;
               end
            end
            default: begin
               state <= IDLE;
               systolic_array_done <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: DATA_W, default 8, element width in bits.
REQ-002 Parameter: N, fixed at 4, array dimension; lanes and buffers are N x N.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start_compute  input  1  level request from controller; high while controller is in COMPUTE.
REQ-006 load_en  input  1  row write strobe into operand buffer.
REQ-007 load_sel  input  1  buffer select: 0 = matrix A, 1 = matrix B.
REQ-008 load_row  input  2  row index written.
REQ-009 load_data  input  4*DATA_W  row elements; element k at bits [k*DATA_W +: DATA_W].
REQ-010 a_out  output  4*DATA_W  row-edge feed; lane i drives array row i.
REQ-011 b_out  output  4*DATA_W  column-edge feed; lane j drives array column j.
REQ-012 a_vld, b_vld  output  4 each  per-lane valid for a_out / b_out.
REQ-013 acc_clr  output  1  one-cycle accumulator clear to array.
REQ-014 systolic_array_done  output  1  one-cycle completion pulse to controller.
REQ-015 busy  output  1  high when state is not IDLE.

Function
REQ-016 FSM states: IDLE, FEED, DRAIN, DONE; all outputs registered.
REQ-017 Edge numbering: edge 0 is the edge at which IDLE samples start_compute=1.
REQ-018 IDLE: start_compute=1 -> FEED at edge 0, acc_clr<=1, step counter<=0.
REQ-019 FEED: acc_clr<=0 at edge 1; at edges 1..7, step c = edge-1 (0..2N-2) is registered onto lanes.
REQ-020 Step c, lane i: if 0 <= c-i <= 3, a_out lane i <= A[i][c-i] and a_vld[i] <= 1; otherwise lane <= 0 and a_vld[i] <= 0.
REQ-021 Step c, lane j: if 0 <= c-j <= 3, b_out lane j <= B[c-j][j] and b_vld[j] <= 1; otherwise lane <= 0 and b_vld[j] <= 0.
REQ-022 Edge 8: lanes and valids <= 0; state -> DRAIN; drain counter <= 0.
REQ-023 DRAIN lasts 2N-1 = 7 cycles with lanes zero; edge 15: systolic_array_done <= 1, state -> DONE.
REQ-024 DONE: edge 16: systolic_array_done <= 0, state -> IDLE; start_compute is ignored while in DONE.
REQ-025 After DONE, IDLE with start_compute=1 re-runs from edge 0 using current buffer contents.
REQ-026 Abort: start_compute=0 sampled in FEED or DRAIN -> IDLE at that edge; lanes, valids and acc_clr <= 0; no done pulse.
REQ-027 Writes: load_en=1 in IDLE writes load_data to A or B row load_row at that edge.
REQ-028 load_en while busy=1 is ignored; buffers are unchanged.
REQ-029 Simultaneous load_en and start in IDLE: the write is accepted, and feed steps use the updated buffer.
REQ-030 Elements pass through unmodified; no arithmetic, and width stays DATA_W.

Reset
REQ-031 rst=0 asynchronously forces IDLE and clears counters and all A/B buffer entries.
REQ-032 rst=0 clears a_out, b_out, a_vld, b_vld, acc_clr, systolic_array_done and busy to 0.
REQ-033 Reset mid-operation: no done pulse; after release the block waits in IDLE for start_compute.

Verification
REQ-034 Load A rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} and B = identity, then hold start -> edge 2 lanes: a_out={0,0,5,2}, a_vld=0011 (lane 3..0); b_out={0,0,0,0} with b_vld=0011.
REQ-035 Full run with start held -> acc_clr high for exactly cycle 1; a_vld[0] high for edges 1..4 and a_vld[3] for edges 4..7; systolic_array_done high exactly after edge 15, low after 16.
REQ-036 Drop start at edge 5 -> all outputs 0 after edge 5; busy=0; no done pulse ever.
REQ-037 load_en with A row0={9,9,9,9} during FEED -> ignored; next run shows A[0][0]=1 on lane 0.
REQ-038 rst=0 at edge 10 (DRAIN) -> busy=0 and all outputs 0 immediately, before any clock edge; after release a new start shows zeroed buffers (lanes 0, valids follow REQ-020/021).
REQ-039 Back-to-back: start held through DONE -> done pulse occurs, IDLE for one cycle, new acc_clr two edges after the done pulse.
